// File: rtl/wishbone_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_mem_bridge
// Function : Converts a level-held MEM-stage request (read/write, size,
//            address, data) into classic Wishbone single-beat master cycles.
//            Sub-word reads are right-justified and zero-extended, misaligned
//            accesses are rejected without a bus cycle, and each bus cycle is
//            bounded by a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_mem_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wsel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] c_sz_word = 2'b01;
  localparam logic [1:0] c_sz_half = 2'b10;
  localparam logic [1:0] c_sz_byte = 2'b11;

  // Counter value on the last permitted BUS cycle
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_rd;
  logic [1:0]       r_size;
  logic [1:0]       r_lane;

  logic             w_req;
  logic             w_misaligned;
  logic             w_bus_done;
  logic [3:0]       w_rd_sel;
  logic [31:0]      w_shifted;
  logic [31:0]      w_rd_data;

  logic [31:0]      w_rdata_nxt;
  logic             w_ack_nxt;
  logic             w_err_nxt;
  logic             w_cyc_nxt;
  logic             w_we_nxt;
  logic [31:0]      w_adr_nxt;
  logic [31:0]      w_dat_nxt;
  logic [3:0]       w_sel_nxt;

  // A write has no size of its own, so only reads are alignment-checked
  assign w_req        = mem_write | (mem_read != 2'b00);
  assign w_misaligned = !mem_write &&
                        (((mem_read == c_sz_word) && (mem_addr[1:0] != 2'b00)) ||
                         ((mem_read == c_sz_half) && mem_addr[0]));
  assign w_bus_done   = wb_err_i | wb_ack_i | (r_cnt == c_cnt_last);

  // Read byte selects derived from request size and low address bits
  always_comb begin
    w_rd_sel = 4'b1111;
    case (mem_read)
      c_sz_half: w_rd_sel = 4'b0011 << {mem_addr[1], 1'b0};
      c_sz_byte: w_rd_sel = 4'b0001 << mem_addr[1:0];
      default:   w_rd_sel = 4'b1111;
    endcase
  end

  // Right-justify the addressed lane and zero-extend to the access size
  assign w_shifted = wb_dat_i >> {r_lane, 3'b000};
  always_comb begin
    w_rd_data = w_shifted;
    case (r_size)
      c_sz_byte: w_rd_data = {24'h0, w_shifted[7:0]};
      c_sz_half: w_rd_data = {16'h0, w_shifted[15:0]};
      default:   w_rd_data = w_shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = w_misaligned ? S_RESP : S_BUS;
      S_BUS:   if (w_bus_done) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; bus fields hold unless changed
  always_comb begin
    w_rdata_nxt = 32'h0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_cyc_nxt   = wb_cyc_o;
    w_we_nxt    = wb_we_o;
    w_adr_nxt   = wb_adr_o;
    w_dat_nxt   = wb_dat_o;
    w_sel_nxt   = wb_sel_o;
    case (r_state)
      S_IDLE: begin
        if (w_req && w_misaligned) begin
          w_ack_nxt = 1'b1;
          w_err_nxt = 1'b1;
        end else if (w_req) begin
          w_cyc_nxt = 1'b1;
          w_we_nxt  = mem_write;
          w_adr_nxt = {mem_addr[31:2], 2'b00};
          w_dat_nxt = mem_write ? mem_wdata : 32'h0;
          w_sel_nxt = mem_write ? mem_wsel : w_rd_sel;
        end
      end
      S_BUS: begin
        if (w_bus_done) begin
          w_ack_nxt = 1'b1;
          // Error outranks ack; a timeout is an error too
          w_err_nxt = wb_err_i | !wb_ack_i;
          if (wb_ack_i && !wb_err_i && r_is_rd) w_rdata_nxt = w_rd_data;
          w_cyc_nxt = 1'b0;
          w_we_nxt  = 1'b0;
          w_adr_nxt = 32'h0;
          w_dat_nxt = 32'h0;
          w_sel_nxt = 4'h0;
        end
      end
      default: ;
    endcase
  end

  // Output registers, request latches and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= 32'h0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= 32'h0;
      wb_dat_o  <= 32'h0;
      wb_sel_o  <= 4'h0;
      r_cnt     <= '0;
      r_is_rd   <= 1'b0;
      r_size    <= 2'b00;
      r_lane    <= 2'b00;
    end else begin
      mem_rdata <= w_rdata_nxt;
      mem_ack   <= w_ack_nxt;
      mem_err   <= w_err_nxt;
      wb_cyc_o  <= w_cyc_nxt;
      wb_stb_o  <= w_cyc_nxt;
      wb_we_o   <= w_we_nxt;
      wb_adr_o  <= w_adr_nxt;
      wb_dat_o  <= w_dat_nxt;
      wb_sel_o  <= w_sel_nxt;
      if (r_state == S_BUS) r_cnt <= r_cnt + 1'b1;
      else                  r_cnt <= '0;
      if (r_state == S_IDLE && w_req) begin
        r_is_rd <= !mem_write;
        r_size  <= mem_read;
        r_lane  <= mem_addr[1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_mem_bridge
// Function : Scoreboard bench for wishbone_mem_bridge. Stimulus pushes the
//            expected response and bus cycle; independent monitors pop and
//            compare when the DUT presents mem_ack or starts/ends a cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_mem_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mem_read;
  logic        mem_write;
  logic [3:0]  mem_wsel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  wishbone_mem_bridge #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wsel(mem_wsel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic [7:0]  len;
  } bus_t;

  resp_t rq[$];
  bus_t  bq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave model: responds after slv_waits wait states with the chosen mode
  // (0 none, 1 ack, 2 err, 3 ack+err)
  int          slv_waits = 0;
  logic [1:0]  slv_mode  = 2'd1;
  logic [31:0] slv_data  = 32'h0;
  int          slv_cnt   = 0;
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o) begin
      wb_ack_i = (slv_cnt == slv_waits) && slv_mode[0];
      wb_err_i = (slv_cnt == slv_waits) && slv_mode[1];
      wb_dat_i = slv_data;
      slv_cnt++;
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      slv_cnt  = 0;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    resp_t e;
    if (mem_ack) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got rdata 0x%08h err %0b, none expected", mem_rdata, mem_err);
      end else begin
        e = rq.pop_front();
        chk("resp_rdata", mem_rdata, e.rdata);
        chk("resp_err", 32'(mem_err), 32'(e.err));
      end
    end else if (mem_err) begin
      chk("err_without_ack", 32'(mem_err), 32'h0);
    end
  end

  // Bus-cycle monitor: fields on the first cycle, length when cyc drops
  bit   in_cyc = 1'b0;
  bus_t cur;
  int   blen = 0;
  always @(negedge clk) begin
    if (wb_cyc_o) begin
      if (!in_cyc) begin
        in_cyc = 1'b1;
        blen   = 1;
        if (bq.size() == 0) begin
          n_cmp++;
          n_bad++;
          cur = '0;
          $display("FAIL unexpected_cycle: got adr 0x%08h, no cycle expected", wb_adr_o);
        end else begin
          cur = bq.pop_front();
          chk("bus_adr", wb_adr_o, cur.adr);
          chk("bus_sel", 32'(wb_sel_o), 32'(cur.sel));
          chk("bus_we", 32'(wb_we_o), 32'(cur.we));
          chk("bus_dat", wb_dat_o, cur.dat);
          chk("bus_stb", 32'(wb_stb_o), 32'h1);
        end
      end else begin
        blen++;
      end
    end else if (in_cyc) begin
      in_cyc = 1'b0;
      chk("bus_len", 32'(blen), 32'(cur.len));
    end
  end

  task automatic do_req(input string name,
                        input logic [1:0] rd, input logic wr, input logic [3:0] wsel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [1:0] mode, input logic [31:0] sdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input bit has_bus, input logic [3:0] exp_sel,
                        input logic [7:0] exp_len, input int exp_lat);
    bus_t  b;
    resp_t r;
    int    lat;
    slv_waits = waits;
    slv_mode  = mode;
    slv_data  = sdata;
    r.rdata = exp_rdata;
    r.err   = exp_err;
    rq.push_back(r);
    if (has_bus) begin
      b.adr = {addr[31:2], 2'b00};
      b.sel = exp_sel;
      b.we  = wr;
      b.dat = wr ? wdata : 32'h0;
      b.len = exp_len;
      bq.push_back(b);
    end
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_wsel  = wsel;
    mem_addr  = addr;
    mem_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ack && lat < 40);
    mem_read  = 2'b00;
    mem_write = 1'b0;
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_read  = 2'b00;
    mem_write = 1'b0;
    mem_wsel  = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    wb_dat_i  = 32'h0;
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_ctrl", {25'h0, mem_ack, mem_err, wb_cyc_o, wb_stb_o, wb_we_o, 2'b00}, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel", 32'(wb_sel_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    //      name        rd     wr  wsel  addr          wdata         w  mode  slave data     exp rdata     err bus sel      len lat
    do_req("rd_word",  2'b01, 0, 4'h0, 32'h0000_1000, 32'h0,        0, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, 4'b1111, 1, 2);
    do_req("rd_byte3", 2'b11, 0, 4'h0, 32'h0000_1003, 32'h0,        0, 2'd1, 32'hAB12_3456, 32'h0000_00AB, 0, 1, 4'b1000, 1, 2);
    do_req("rd_half2", 2'b10, 0, 4'h0, 32'h0000_1002, 32'h0,        0, 2'd1, 32'hAB12_3456, 32'h0000_AB12, 0, 1, 4'b1100, 1, 2);
    do_req("rd_byte0", 2'b11, 0, 4'h0, 32'h0000_1000, 32'h0,        1, 2'd1, 32'hAB12_3456, 32'h0000_0056, 0, 1, 4'b0001, 2, 3);
    do_req("rd_half0", 2'b10, 0, 4'h0, 32'h0000_1000, 32'h0,        0, 2'd1, 32'hAB12_3456, 32'h0000_3456, 0, 1, 4'b0011, 1, 2);
    do_req("rd_byte1", 2'b11, 0, 4'h0, 32'h0000_1001, 32'h0,        0, 2'd1, 32'hAB12_3456, 32'h0000_0034, 0, 1, 4'b0010, 1, 2);
    do_req("wr_wait3", 2'b00, 1, 4'hF, 32'h0000_2000, 32'h1234_5678, 3, 2'd1, 32'hFFFF_FFFF, 32'h0,        0, 1, 4'b1111, 4, 5);
    do_req("mis_word", 2'b01, 0, 4'h0, 32'h0000_1002, 32'h0,        0, 2'd1, 32'h5555_5555, 32'h0,         1, 0, 4'h0,    0, 1);
    do_req("mis_half", 2'b10, 0, 4'h0, 32'h0000_1001, 32'h0,        0, 2'd1, 32'h5555_5555, 32'h0,         1, 0, 4'h0,    0, 1);
    do_req("timeout",  2'b01, 0, 4'h0, 32'h0000_3000, 32'h0,        0, 2'd0, 32'h7777_7777, 32'h0,         1, 1, 4'b1111, 4, 5);
    do_req("ack_err",  2'b01, 0, 4'h0, 32'h0000_3004, 32'h0,        0, 2'd3, 32'h7777_7777, 32'h0,         1, 1, 4'b1111, 1, 2);
    do_req("err_only", 2'b11, 0, 4'h0, 32'h0000_3006, 32'h0,        2, 2'd2, 32'h7777_7777, 32'h0,         1, 1, 4'b0100, 3, 4);

    // Reset in the middle of a bus cycle: cyc drops at once, no ack follows
    slv_mode = 2'd0;
    bq.push_back('{adr: 32'h0000_4000, sel: 4'b1111, we: 1'b0, dat: 32'h0, len: 8'd2});
    @(negedge clk);
    mem_read = 2'b01;
    mem_addr = 32'h0000_4000;
    repeat (2) @(negedge clk);
    #2;
    rst_n    = 1'b0;
    mem_read = 2'b00;
    #1;
    chk("rst_mid_cyc", 32'(wb_cyc_o), 32'h0);
    chk("rst_mid_stb", 32'(wb_stb_o), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_req("post_rst", 2'b01, 0, 4'h0, 32'h0000_5000, 32'h0,        0, 2'd1, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 1, 4'b1111, 1, 2);
    do_req("rd_and_wr", 2'b01, 1, 4'b0101, 32'h0000_6000, 32'hCAFE_F00D, 0, 2'd1, 32'h1111_1111, 32'h0,   0, 1, 4'b0101, 1, 2);

    repeat (4) @(negedge clk);
    chk("resp_queue_left", 32'(rq.size()), 32'h0);
    chk("bus_queue_left", 32'(bq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
